// File: rtl/sram_readout.sv
// Read-back engine for the capture SRAM: walks downward from the write pointer, newest sample
// first, and streams each byte on a valid/ready port. Define READOUT_CHECKSUM_EN to append an XOR byte.
module sram_readout #(
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 8,
    parameter int CNT_W       = 13,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              osc_clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] end_address,
    input  logic [CNT_W-1:0]  sample_reg,
    input  logic [DATA_W-1:0] sram_data,
    output logic [ADDR_W-1:0] sram_address,
    output logic              sram_oe,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam int WC_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int REM_W = CNT_W + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_SEND,
`ifdef READOUT_CHECKSUM_EN
        S_CKSUM,
`endif
        S_DONE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [WC_W-1:0]   wcnt_q;
    logic              oe_q, txv_q, busy_q, done_q;
    logic [DATA_W-1:0] txd_q;
`ifdef READOUT_CHECKSUM_EN
    logic [DATA_W-1:0] cksum_q;
`endif

    // Address decrement wraps 0 -> all-ones without any special casing.
    assign addr_d = addr_q - 1'b1;
    assign rem_d  = rem_q - 1'b1;

    always_ff @(posedge osc_clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            wcnt_q  <= '0;
            oe_q    <= 1'b0;
            txd_q   <= '0;
            txv_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
            cksum_q <= '0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        addr_q  <= end_address - 1'b1;
                        rem_q   <= {sample_reg, 2'b11};
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
                        cksum_q <= '0;
`endif
                        state_q <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    oe_q    <= 1'b1;
                    wcnt_q  <= WC_W'(WAIT_CYCLES - 1);
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (wcnt_q == '0) begin
                        txd_q   <= sram_data;
                        txv_q   <= 1'b1;
                        oe_q    <= 1'b0;
                        state_q <= S_SEND;
                    end else begin
                        wcnt_q <= wcnt_q - 1'b1;
                    end
                end
                S_SEND: begin
                    if (txv_q && tx_ready) begin
                        txv_q <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
                        cksum_q <= cksum_q ^ txd_q;
`endif
                        if (rem_q == '0) begin
`ifdef READOUT_CHECKSUM_EN
                            state_q <= S_CKSUM;
`else
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
`endif
                        end else begin
                            rem_q   <= rem_d;
                            addr_q  <= addr_d;
                            state_q <= S_ADDR;
                        end
                    end
                end
`ifdef READOUT_CHECKSUM_EN
                S_CKSUM: begin
                    // First cycle loads the byte; it then follows the same handshake as a sample.
                    if (!txv_q) begin
                        txd_q <= cksum_q;
                        txv_q <= 1'b1;
                    end else if (tx_ready) begin
                        txv_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sram_address = addr_q;
    assign sram_oe      = oe_q;
    assign tx_data      = txd_q;
    assign tx_valid     = txv_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_sram_readout.sv
// Scoreboard bench for sram_readout: expected bytes/addresses are queued at start and
// popped as each handshake is observed on the falling edge.
module tb_sram_readout;

    logic        osc_clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [14:0] end_address = '0;
    logic [12:0] sample_reg = '0;
    logic [7:0]  sram_data;
    logic [14:0] sram_address;
    logic        sram_oe;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic        done;

    int vecs = 0;
    int errs = 0;
    logic       use_tab = 1'b0;
    logic [7:0] tab [0:3];

    sram_readout dut (
        .osc_clock    (osc_clock),
        .reset        (reset),
        .start        (start),
        .end_address  (end_address),
        .sample_reg   (sample_reg),
        .sram_data    (sram_data),
        .sram_address (sram_address),
        .sram_oe      (sram_oe),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .done         (done)
    );

    always #5 osc_clock = ~osc_clock;

    // SRAM model: a small lookup table or an address hash
    always_comb
        sram_data = use_tab ? tab[sram_address[1:0]] : (sram_address[7:0] ^ {sram_address[14:8], 1'b0});

    function automatic logic [7:0] exp_byte(input logic [14:0] a);
        logic [1:0] i;
        i = a[1:0];
        return use_tab ? tab[i] : (a[7:0] ^ {a[14:8], 1'b0});
    endfunction

    task automatic run_xfer(input logic [14:0] ea, input logic [12:0] sr,
                            input int bp_at, input int start_at, input string nm);
        logic [7:0]  dq[$];
        logic [14:0] aq[$];
        logic [7:0]  ck, hd, ed;
        logic [14:0] ha, ea2;
        int n, got, bp_left, cyc;
        bit extra;
        ck = '0; got = 0; cyc = 0; hd = '0; ha = '0;
        n = (int'(sr) + 1) * 4;
        for (int i = 0; i < n; i++) begin
            ea2 = ea - 15'(i + 1);
            aq.push_back(ea2);
            ed = exp_byte(ea2);
            dq.push_back(ed);
            ck ^= ed;
        end
`ifdef READOUT_CHECKSUM_EN
        dq.push_back(ck);
`endif
        bp_left = (bp_at >= 0) ? 5 : 0;
        @(negedge osc_clock);
        start = 1'b1; end_address = ea; sample_reg = sr; tx_ready = 1'b1;
        @(negedge osc_clock);
        start = 1'b0;
        vecs++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errs++;
            $display("FAIL %s start_status busy=%b done=%b expected busy=1 done=0", nm, busy, done);
        end
        while (dq.size() > 0 && cyc < 4000) begin
            start = (cyc == start_at);
            if (tx_valid === 1'b1) begin
                if (got == bp_at && bp_left > 0) begin
                    tx_ready = 1'b0;
                    if (bp_left == 5) begin
                        hd = tx_data; ha = sram_address;
                    end else begin
                        vecs++;
                        if (tx_data !== hd || sram_address !== ha) begin
                            errs++;
                            $display("FAIL %s backpressure_hold data=%h addr=%h expected data=%h addr=%h",
                                     nm, tx_data, sram_address, hd, ha);
                        end
                    end
                    bp_left--;
                end else begin
                    tx_ready = 1'b1;
                    ed = dq.pop_front();
                    vecs++;
                    if (tx_data !== ed) begin
                        errs++;
                        $display("FAIL %s byte%0d tx_data=%h expected %h", nm, got, tx_data, ed);
                    end
                    if (aq.size() > 0) begin
                        ea2 = aq.pop_front();
                        vecs++;
                        if (sram_address !== ea2) begin
                            errs++;
                            $display("FAIL %s addr%0d sram_address=%h expected %h", nm, got, sram_address, ea2);
                        end
                    end
                    got++;
                end
            end else begin
                tx_ready = 1'b1;
            end
            @(negedge osc_clock);
            cyc++;
        end
        start = 1'b0;
        tx_ready = 1'b1;
        vecs++;
        if (cyc >= 4000) begin
            errs++;
            $display("FAIL %s timeout bytes_received=%0d expected %0d", nm, got, dq.size() + got);
        end
        extra = 1'b0;
        repeat (6) begin
            @(negedge osc_clock);
            if (tx_valid !== 1'b0) extra = 1'b1;
        end
        vecs++;
        if (extra) begin
            errs++;
            $display("FAIL %s extra_byte tx_valid seen after %0d bytes", nm, got);
        end
        vecs++;
        if (done !== 1'b1 || busy !== 1'b0 || sram_oe !== 1'b0) begin
            errs++;
            $display("FAIL %s end_status done=%b busy=%b oe=%b expected done=1 busy=0 oe=0", nm, done, busy, sram_oe);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge osc_clock);
        vecs++;
        if ({sram_address, sram_oe, tx_data, tx_valid, busy, done} !== '0) begin
            errs++;
            $display("FAIL reset_state addr=%h oe=%b data=%h valid=%b busy=%b done=%b expected all 0",
                     sram_address, sram_oe, tx_data, tx_valid, busy, done);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        use_tab = 1'b1;
        run_xfer(15'h0010, 13'd0, -1, -1, "basic");
        use_tab = 1'b0;
    endtask

    task automatic test_wrap;
        run_xfer(15'h0002, 13'd0, -1, -1, "wrap");
    endtask

    task automatic test_backpressure;
        run_xfer(15'h0100, 13'd1, 2, -1, "backpressure");
    endtask

    task automatic test_start_busy;
        run_xfer(15'h1234, 13'd0, -1, 3, "start_busy");
    endtask

    task automatic test_back_to_back;
        logic [14:0] ea;
        ea = 15'($urandom);
        run_xfer(ea, 13'd3, -1, -1, "b2b_a");
        run_xfer(ea ^ 15'h5A5A, 13'd2, 5, -1, "b2b_b");
    endtask

    task automatic test_reset_mid;
        int cnt;
        bit bad;
        cnt = 0;
        @(negedge osc_clock);
        start = 1'b1; end_address = 15'h0040; sample_reg = 13'd0;
        @(negedge osc_clock);
        start = 1'b0; tx_ready = 1'b0;
        while (tx_valid !== 1'b1 && cnt < 50) begin
            @(negedge osc_clock);
            cnt++;
        end
        vecs++;
        if (cnt >= 50) begin
            errs++;
            $display("FAIL reset_mid timeout waiting for tx_valid");
        end
        reset = 1'b1;
        #1;
        vecs++;
        if ({sram_address, sram_oe, tx_data, tx_valid, busy, done} !== '0) begin
            errs++;
            $display("FAIL reset_mid outputs addr=%h oe=%b data=%h valid=%b busy=%b done=%b expected all 0",
                     sram_address, sram_oe, tx_data, tx_valid, busy, done);
        end
        @(negedge osc_clock);
        reset = 1'b0; tx_ready = 1'b1;
        bad = 1'b0;
        repeat (8) begin
            @(negedge osc_clock);
            if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
        end
        vecs++;
        if (bad) begin
            errs++;
            $display("FAIL reset_mid_after activity after reset valid=%b busy=%b done=%b expected 0", tx_valid, busy, done);
        end
        run_xfer(15'h0007, 13'd0, -1, -1, "after_reset");
    endtask

    initial begin
        tab[0] = 8'h88; tab[1] = 8'h44; tab[2] = 8'h22; tab[3] = 8'h11;
        test_reset;
        test_basic;
        test_wrap;
        test_backpressure;
        test_start_busy;
        test_back_to_back;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
